ring_pattern_gen: RTL and testbench
===================================

RING_PATTERN_GEN -- requirements
Module: ring_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of ring stages (legal range 3..32).
REQ-002 SHALL have parameter LFSR_TAPS, default 8'hB8 (WIDTH bits), Fibonacci feedback tap mask.
REQ-003 SHALL have parameter INVERT_OUT, default 1; when 1, q presents inverted stage values.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  step enable.
REQ-007 mode  input  2  00 HOLD, 01 SHIFT, 10 ROTATE, 11 LFSR.
REQ-008 din  input  1  serial data for SHIFT mode.
REQ-009 load_valid  input  1  parallel-load request.
REQ-010 load_data  input  WIDTH  parallel-load value.
REQ-011 load_ready  output  1  parallel-load acceptance.
REQ-012 tap_sel  input  $clog2(WIDTH)  stage index for tap_out.
REQ-013 q  output  WIDTH  stage values, inverted per INVERT_OUT.
REQ-014 tap_out  output  1  stage[tap_sel], combinational.
REQ-015 count  output  $clog2(WIDTH)  step counter.
REQ-016 wrap  output  1  one-cycle pulse on counter wrap.

Function
REQ-017 SHALL accept a load when load_valid and load_ready are both high: state <= load_data and count <= 0; a load has priority over any step in that cycle.
REQ-018 SHALL drive load_ready low for exactly the one cycle after an accepted load and high otherwise; load_valid while load_ready is low SHALL be ignored.
REQ-019 SHALL hold state and count when en=0 or mode=HOLD.
REQ-020 In SHIFT, SHALL perform state <= {state[WIDTH-2:0], din}.
REQ-021 In ROTATE, SHALL perform state <= {state[WIDTH-2:0], state[WIDTH-1]}.
REQ-022 In LFSR, SHALL perform state <= {state[WIDTH-2:0], ^(state & LFSR_TAPS)}.
REQ-023 In LFSR, when state is all-zero, the step SHALL instead set state to 1 (lock-up recovery).
REQ-024 Each step in SHIFT/ROTATE/LFSR SHALL increment count modulo WIDTH; count = WIDTH-1 SHALL step to 0.
REQ-025 wrap SHALL be registered and high for exactly the cycle after a step moved count from WIDTH-1 to 0; a load SHALL never assert wrap.
REQ-026 A mode change SHALL NOT reset count or state; the next step uses the new mode.
REQ-027 tap_out SHALL be 0 when tap_sel >= WIDTH.
REQ-028 q SHALL equal ~state when INVERT_OUT=1, and state otherwise.

Reset
REQ-029 On rst_n low, SHALL immediately set state=0, count=0, wrap=0 and load_ready=1, independent of clk.
REQ-030 Consequently, q SHALL be all-ones during and after reset when INVERT_OUT=1.
REQ-031 Reset asserted mid-operation SHALL discard any pending load or step with no residual pulse.

Structure
REQ-032 SHALL place a mode enum typedef (HOLD/SHIFT/ROTATE/LFSR) and its 2-bit encodings in shared package ring_pattern_pkg.
REQ-033 SHALL isolate the combinational next-state selection (shift/rotate/LFSR/lock-up) in one sub-module, ring_next_state.
REQ-034 state, count, wrap and load_ready SHALL be the only registers.

Verification (WIDTH=8, LFSR_TAPS=8'hB8, INVERT_OUT=1)
REQ-035 Assert rst_n=0 -> q=8'hFF, count=0, wrap=0, load_ready=1, without any clk edge.
REQ-036 mode=01, en=1, din=1,0,1,1 over 4 cycles -> state=8'h0B, q=8'hF4, count=4.
REQ-037 Load 8'h81, then ROTATE for 8 steps -> state=8'h81, count=0, wrap high for one cycle after the 8th step.
REQ-038 Load 8'h00, then one LFSR step -> state=8'h01; next step -> 8'h02.
REQ-039 load_valid with load_data=8'hA5 in the same cycle as an en=1 ROTATE -> state=8'hA5, count=0, load_ready=0 for one cycle; a second load_valid in that cycle is ignored.
REQ-040 rst_n pulsed low mid-ROTATE at count=7 -> state=0, count=0, and no wrap pulse afterwards.

Source files
------------

// File: rtl/ring_pattern_pkg.sv
// Shared definitions for the ring pattern generator: step modes and their encodings.
package ring_pattern_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    HOLD   = 2'b00,
    SHIFT  = 2'b01,
    ROTATE = 2'b10,
    LFSR   = 2'b11
  } mode_t;

endpackage

// File: rtl/ring_next_state.sv
// Combinational next-state selection for the ring: shift, rotate, Fibonacci LFSR.
// Zero latency, no flow control; the caller decides whether the result is taken.
module ring_next_state
  import ring_pattern_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic [WIDTH-1:0] state,
  input  mode_t            mode,
  input  logic             din,
  output logic [WIDTH-1:0] next_state
);

  always_comb begin
    next_state = state;
    case (mode)
      HOLD:   next_state = state;
      SHIFT:  next_state = {state[WIDTH-2:0], din};
      ROTATE: next_state = {state[WIDTH-2:0], state[WIDTH-1]};
      LFSR: begin
        // All-zero is a fixed point of the XOR feedback, so kick it to 1.
        if (state == '0) next_state = WIDTH'(1);
        else             next_state = {state[WIDTH-2:0], ^(state & LFSR_TAPS)};
      end
      default: next_state = state;
    endcase
  end

endmodule

// File: rtl/ring_pattern_gen.sv
// Ring/LFSR pattern generator with parallel load; one-cycle step latency.
// load_ready drops for the cycle after an accepted load; requests then are ignored.
module ring_pattern_gen
  import ring_pattern_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS  = 8'hB8,
  parameter bit               INVERT_OUT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     din,
  input  logic                     load_valid,
  input  logic [WIDTH-1:0]         load_data,
  output logic                     load_ready,
  input  logic [$clog2(WIDTH)-1:0] tap_sel,
  output logic [WIDTH-1:0]         q,
  output logic                     tap_out,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic                     wrap
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] next_state;
  mode_t            mode_e;
  logic             load_acc;
  logic             step;

  assign mode_e   = mode_t'(mode);
  assign load_acc = load_valid && load_ready;
  assign step     = en && (mode_e != HOLD);

  ring_next_state #(
    .WIDTH     (WIDTH),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_next (
    .state      (state),
    .mode       (mode_e),
    .din        (din),
    .next_state (next_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= '0;
      count      <= '0;
      wrap       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      load_ready <= !load_acc;
      wrap       <= 1'b0;
      // A load wins over a step and never produces a wrap pulse.
      if (load_acc) begin
        state <= load_data;
        count <= '0;
      end else if (step) begin
        state <= next_state;
        count <= (count == LAST) ? '0 : count + CW'(1);
        wrap  <= (count == LAST);
      end
    end
  end

  assign q       = INVERT_OUT ? ~state : state;
  assign tap_out = (int'(tap_sel) < WIDTH) ? state[tap_sel] : 1'b0;

endmodule

// File: tb/tb_ring_pattern_gen.sv
// Scoreboard bench for ring_pattern_gen: directed scenarios plus randomized traffic.
module tb_ring_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       din = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_ready;
  logic [2:0] tap_sel = 3'd0;
  logic [7:0] q;
  logic       tap_out;
  logic [2:0] count;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] q;
    int         count;
    bit         wrap;
    bit         ready;
    bit         tap;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: plain integer arithmetic on the ring contents.
  int m_state = 0;
  int m_count = 0;
  bit m_wrap  = 0;
  bit m_ready = 1;

  ring_pattern_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .din        (din),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .tap_sel    (tap_sel),
    .q          (q),
    .tap_out    (tap_out),
    .count      (count),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_count = 0;
    m_wrap  = 0;
    m_ready = 1;
  endtask

  task automatic model_step();
    bit acc;
    int fb;
    acc    = load_valid && m_ready;
    m_wrap = 0;
    if (acc) begin
      m_state = int'(load_data);
      m_count = 0;
    end else if (en && mode != 2'b00) begin
      case (mode)
        2'b01: m_state = ((m_state * 2) + int'(din)) % 256;
        2'b10: m_state = ((m_state * 2) + (m_state / 128)) % 256;
        default: begin
          if (m_state == 0) m_state = 1;
          else begin
            fb = $countones(m_state & 'hB8) % 2;
            m_state = ((m_state * 2) + fb) % 256;
          end
        end
      endcase
      if (m_count == 7) m_wrap = 1;
      m_count = (m_count + 1) % 8;
    end
    m_ready = !acc;
  endtask

  // One cycle: let the edge apply the previous inputs, then present new ones.
  task automatic drive(input bit e, input logic [1:0] m, input bit d,
                       input bit lv, input logic [7:0] ld, input logic [2:0] ts);
    exp_t x;
    logic [7:0] s8;
    @(posedge clk);
    model_step();
    #1;
    en = e; mode = m; din = d; load_valid = lv; load_data = ld; tap_sel = ts;
    s8      = 8'(m_state);
    x.q     = ~s8;
    x.count = m_count;
    x.wrap  = m_wrap;
    x.ready = m_ready;
    x.tap   = s8[ts];
    exp_q.push_back(x);
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 3'd0);
  endtask

  // Called just after an edge; asserts reset between edges and holds it over one edge.
  task automatic pulse_reset();
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("rst_q", q, 8'hFF);
    check("rst_count", count, 0);
    check("rst_wrap", wrap, 0);
    check("rst_ready", load_ready, 1);
    model_reset();
    @(posedge clk);
    #1;
    en = 0; mode = 2'b00; load_valid = 0;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_q", q, e.q);
      check("sb_count", count, e.count);
      check("sb_wrap", wrap, e.wrap);
      check("sb_ready", load_ready, e.ready);
      check("sb_tap", tap_out, e.tap);
    end
  end

  initial begin
    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("init_q", q, 8'hFF);
    check("init_count", count, 0);
    check("init_wrap", wrap, 0);
    check("init_ready", load_ready, 1);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Shift in 1,0,1,1.
    drive(1, 2'b01, 1, 0, 8'h00, 3'd0);
    drive(1, 2'b01, 0, 0, 8'h00, 3'd1);
    drive(1, 2'b01, 1, 0, 8'h00, 3'd2);
    drive(1, 2'b01, 1, 0, 8'h00, 3'd3);
    idle();
    check("shift_q", q, 8'hF4);
    check("shift_count", count, 4);

    // Load then a full rotation.
    drive(0, 2'b00, 0, 1, 8'h81, 3'd0);
    for (int i = 0; i < 8; i++) drive(1, 2'b10, 0, 0, 8'h00, 3'(i));
    idle();
    check("rot_q", q, 8'h7E);
    check("rot_count", count, 0);
    check("rot_wrap", wrap, 1);
    idle();
    check("rot_wrap_end", wrap, 0);

    // LFSR lock-up recovery.
    drive(0, 2'b00, 0, 1, 8'h00, 3'd0);
    drive(1, 2'b11, 0, 0, 8'h00, 3'd0);
    idle();
    check("lfsr_q1", q, 8'hFE);
    drive(1, 2'b11, 0, 0, 8'h00, 3'd1);
    idle();
    check("lfsr_q2", q, 8'hFD);

    // Load beats a concurrent rotate; a load during the busy cycle is dropped.
    drive(1, 2'b10, 0, 0, 8'h00, 3'd0);
    drive(1, 2'b10, 0, 1, 8'hA5, 3'd0);
    drive(0, 2'b00, 0, 1, 8'h3C, 3'd0);
    check("ld_q", q, 8'h5A);
    check("ld_count", count, 0);
    check("ld_ready", load_ready, 0);
    idle();
    check("ld_ignored_q", q, 8'h5A);
    check("ld_ready_back", load_ready, 1);

    // Reset mid-rotate at count 7: no wrap pulse may follow.
    drive(0, 2'b00, 0, 1, 8'h81, 3'd0);
    for (int i = 0; i < 7; i++) drive(1, 2'b10, 0, 0, 8'h00, 3'd0);
    drive(1, 2'b10, 0, 0, 8'h00, 3'd0);
    check("pre_rst_count", count, 7);
    pulse_reset();
    idle();
    check("post_rst_wrap", wrap, 0);
    idle();
    check("post_rst_wrap2", wrap, 0);

    // Randomized traffic with occasional mode changes and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        @(posedge clk);
        model_step();
        #1;
        pulse_reset();
      end else begin
        drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom),
              1'($urandom_range(0, 5) == 0), 8'($urandom), 3'($urandom));
      end
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
